// File: rtl/pattern_gen.sv
// VGA test-pattern generator: eight frame-synchronous patterns with a bouncing box
// and scrolling bars, colour registered two cycles after the pixel coordinates.
module pattern_gen #(
  parameter int R_BITS    = 3,
  parameter int G_BITS    = 3,
  parameter int B_BITS    = 2,
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int BOX_SIZE  = 32,
  parameter int SPEED     = 4,
  parameter int CHK_LOG2  = 5,
  parameter int GRID_LOG2 = 6
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [9:0]                       pixel_x,
  input  logic [9:0]                       pixel_y,
  input  logic                             active,
  input  logic [2:0]                       mode,
  input  logic [R_BITS+G_BITS+B_BITS-1:0]  solid_color,
  input  logic                             pause,
  output logic [R_BITS+G_BITS+B_BITS-1:0]  color_out,
  output logic                             frame_tick,
  output logic [15:0]                      frame_cnt
);

  localparam int CW = R_BITS + G_BITS + B_BITS;
  // Position arithmetic is kept wide enough that pos + SPEED or pos + BOX_SIZE never wraps.
  localparam int PW = 12;

  localparam logic [PW-1:0] H_L    = PW'(H_ACTIVE);
  localparam logic [PW-1:0] V_L    = PW'(V_ACTIVE);
  localparam logic [PW-1:0] H_LAST = PW'(H_ACTIVE - 1);
  localparam logic [PW-1:0] V_LAST = PW'(V_ACTIVE - 1);
  localparam logic [PW-1:0] BOX_L  = PW'(BOX_SIZE);
  localparam logic [PW-1:0] SPD    = PW'(SPEED);
  localparam logic [PW-1:0] X_MAX  = PW'(H_ACTIVE - BOX_SIZE);
  localparam logic [PW-1:0] Y_MAX  = PW'(V_ACTIVE - BOX_SIZE);
  localparam logic [CW-1:0] WHITE  = {CW{1'b1}};
  localparam logic [CW-1:0] BLACK  = {CW{1'b0}};

  typedef enum logic [2:0] {
    M_SOLID   = 3'd0,
    M_BARS    = 3'd1,
    M_CHECKER = 3'd2,
    M_GRAD    = 3'd3,
    M_GRID    = 3'd4,
    M_BOX     = 3'd5,
    M_SCROLL  = 3'd6,
    M_BLACK   = 3'd7
  } mode_e;

  // Bar index 0..7 for a coordinate already known to be inside the active width.
  function automatic logic [2:0] bar_idx(input logic [PW-1:0] xv);
    logic [2:0] idx;
    idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (xv >= PW'(k * (H_ACTIVE / 8))) begin
        idx = 3'(k);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  function automatic logic [CW-1:0] bar_color(input logic [2:0] idx);
    return {{R_BITS{idx[2]}}, {G_BITS{idx[1]}}, {B_BITS{idx[0]}}};
  endfunction

  // One bounce step along an axis; returns {new_dir, new_pos}. Left/top bound is
  // checked before subtracting so the position never underflows.
  function automatic logic [PW:0] axis_step(input logic [PW-1:0] pos, input logic dir,
                                            input logic [PW-1:0] lim);
    logic [PW:0] res;
    if (!dir) begin
      if (pos + SPD >= lim) begin
        res = {1'b1, lim};
      end else begin
        res = {1'b0, pos + SPD};
      end
    end else begin
      if (pos <= SPD) begin
        res = {1'b0, {PW{1'b0}}};
      end else begin
        res = {1'b1, pos - SPD};
      end
    end
    return res;
  endfunction

  logic [9:0]    prev_y_r;
  logic          tick_s;
  logic [9:0]    x1_r;
  logic [9:0]    y1_r;
  logic          act1_r;
  logic [2:0]    mode_q_r;
  logic [CW-1:0] sc_q_r;
  logic [PW-1:0] box_x_r;
  logic [PW-1:0] box_y_r;
  logic          dx_r;
  logic          dy_r;
  logic [PW-1:0] scroll_r;
  logic [15:0]   frame_cnt_r;
  logic          frame_tick_r;
  logic [CW-1:0] color_r;

  logic [PW:0]   x_step_s;
  logic [PW:0]   y_step_s;
  logic [PW-1:0] scroll_sum_s;
  logic [PW-1:0] scroll_nxt_s;
  logic [PW-1:0] x2_s;
  logic [PW-1:0] y2_s;
  logic [PW-1:0] xs_sum_s;
  logic [PW-1:0] xs_s;
  logic          in_box_s;
  logic          on_grid_s;
  logic [CW-1:0] color_s;

  assign color_out  = color_r;
  assign frame_tick = frame_tick_r;
  assign frame_cnt  = frame_cnt_r;

  // Frame start: first line 0 after a non-zero line.
  always_comb begin
    tick_s = (pixel_y == 10'd0) && (prev_y_r != 10'd0);
  end

  // Next animation state: box step and scroll advance.
  always_comb begin
    x_step_s     = axis_step(box_x_r, dx_r, X_MAX);
    y_step_s     = axis_step(box_y_r, dy_r, Y_MAX);
    scroll_sum_s = scroll_r + SPD;
    if (scroll_sum_s >= H_L) begin
      scroll_nxt_s = scroll_sum_s - H_L;
    end else begin
      scroll_nxt_s = scroll_sum_s;
    end
  end

  // Frame-synchronous state: latched mode/colour, box, scroll and frame counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      mode_q_r    <= 3'd0;
      sc_q_r      <= BLACK;
      box_x_r     <= {PW{1'b0}};
      box_y_r     <= {PW{1'b0}};
      dx_r        <= 1'b0;
      dy_r        <= 1'b0;
      scroll_r    <= {PW{1'b0}};
      frame_cnt_r <= 16'd0;
    end else if (tick_s) begin
      mode_q_r <= mode;
      sc_q_r   <= solid_color;
      if (!pause) begin
        frame_cnt_r <= frame_cnt_r + 16'd1;
        box_x_r     <= x_step_s[PW-1:0];
        dx_r        <= x_step_s[PW];
        box_y_r     <= y_step_s[PW-1:0];
        dy_r        <= y_step_s[PW];
        scroll_r    <= scroll_nxt_s;
      end
    end
  end

  // Stage-2 colour selection from the stage-1 registered coordinates.
  always_comb begin
    x2_s     = PW'(x1_r);
    y2_s     = PW'(y1_r);
    xs_sum_s = x2_s + scroll_r;
    if (xs_sum_s >= H_L) begin
      xs_s = xs_sum_s - H_L;
    end else begin
      xs_s = xs_sum_s;
    end
    in_box_s  = (x2_s >= box_x_r) && (x2_s < box_x_r + BOX_L) &&
                (y2_s >= box_y_r) && (y2_s < box_y_r + BOX_L);
    on_grid_s = (x1_r[GRID_LOG2-1:0] == {GRID_LOG2{1'b0}}) ||
                (y1_r[GRID_LOG2-1:0] == {GRID_LOG2{1'b0}}) ||
                (x2_s == H_LAST) || (y2_s == V_LAST);
    color_s = BLACK;
    if (!act1_r || x2_s >= H_L || y2_s >= V_L) begin
      color_s = BLACK;
    end else begin
      case (mode_e'(mode_q_r))
        M_SOLID:   color_s = sc_q_r;
        M_BARS:    color_s = bar_color(bar_idx(x2_s));
        M_CHECKER: color_s = (x1_r[CHK_LOG2] ^ y1_r[CHK_LOG2]) ? WHITE : BLACK;
        M_GRAD:    color_s = {x1_r[7 -: R_BITS], y1_r[7 -: G_BITS],
                              x1_r[B_BITS:1] ^ y1_r[B_BITS:1]};
        M_GRID:    color_s = on_grid_s ? WHITE : BLACK;
        M_BOX:     color_s = in_box_s ? sc_q_r : BLACK;
        M_SCROLL:  color_s = bar_color(bar_idx(xs_s));
        M_BLACK:   color_s = BLACK;
        default:   color_s = BLACK;
      endcase
    end
  end

  // Two-stage pixel pipeline, frame tick register and line history.
  always_ff @(posedge clock) begin
    if (reset) begin
      prev_y_r     <= 10'd0;
      x1_r         <= 10'd0;
      y1_r         <= 10'd0;
      act1_r       <= 1'b0;
      frame_tick_r <= 1'b0;
      color_r      <= BLACK;
    end else begin
      prev_y_r     <= pixel_y;
      x1_r         <= pixel_x;
      y1_r         <= pixel_y;
      act1_r       <= active;
      frame_tick_r <= tick_s;
      color_r      <= color_s;
    end
  end

endmodule

// File: tb/tb_pattern_gen.sv
// Scoreboard bench for pattern_gen: randomized and directed pixels against a
// behavioural frame/pixel model; a negedge monitor checks colour, tick and counter.
module tb_pattern_gen;

  localparam int H = 640;
  localparam int V = 480;
  localparam int BOX = 32;
  localparam int SPEED = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] pixel_x = 10'd0;
  logic [9:0] pixel_y = 10'd0;
  logic       active = 1'b0;
  logic [2:0] mode = 3'd0;
  logic [7:0] solid_color = 8'd0;
  logic       pause = 1'b0;
  logic [7:0] color_out;
  logic       frame_tick;
  logic [15:0] frame_cnt;

  pattern_gen dut (
    .clock(clock), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .active(active), .mode(mode), .solid_color(solid_color), .pause(pause),
    .color_out(color_out), .frame_tick(frame_tick), .frame_cnt(frame_cnt)
  );

  always #5 clock = ~clock;

  typedef struct { int due; int val; } exp_t;
  exp_t cq[$];
  exp_t tq[$];
  exp_t ce;
  exp_t te;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  // Model state
  int m_mode = 0, m_sc = 0, m_bx = 0, m_by = 0, m_dx = 0, m_dy = 0;
  int m_scroll = 0, m_cnt = 0, m_prev_y = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic int bars(input int xv);
    int idx;
    idx = xv / (H / 8);
    return ((idx & 4) != 0 ? 8'hE0 : 0) | ((idx & 2) != 0 ? 8'h1C : 0) | ((idx & 1) != 0 ? 8'h03 : 0);
  endfunction

  function automatic int exp_color(input int x, input int y, input int a);
    if (a == 0 || x >= H || y >= V) return 0;
    case (m_mode)
      0: return m_sc;
      1: return bars(x);
      2: return (((x >> 5) ^ (y >> 5)) & 1) != 0 ? 255 : 0;
      3: return (((x & 255) >> 5) << 5) | (((y & 255) >> 5) << 2) | (((x >> 1) ^ (y >> 1)) & 3);
      4: return (x % 64 == 0 || y % 64 == 0 || x == H - 1 || y == V - 1) ? 255 : 0;
      5: return (x >= m_bx && x < m_bx + BOX && y >= m_by && y < m_by + BOX) ? m_sc : 0;
      6: return bars((x + m_scroll) % H);
      default: return 0;
    endcase
  endfunction

  task automatic bounce(inout int p, inout int d, input int lim);
    if (d == 0) begin
      if (p + SPEED >= lim) begin p = lim; d = 1; end
      else p = p + SPEED;
    end else begin
      if (p <= SPEED) begin p = 0; d = 0; end
      else p = p - SPEED;
    end
  endtask

  // Drive one pixel for one clock and queue what the DUT must show for it.
  task automatic drive(input int x, input int y, input int a, input bit rst);
    int tick;
    pixel_x = 10'(x); pixel_y = 10'(y); active = a[0]; reset = rst;
    tick = 0;
    if (rst) begin
      for (int i = 0; i < cq.size(); i++)
        if (cq[i].due == cyc + 1) cq[i].val = 0;
      m_mode = 0; m_sc = 0; m_bx = 0; m_by = 0; m_dx = 0; m_dy = 0;
      m_scroll = 0; m_cnt = 0; m_prev_y = 0;
    end else begin
      tick = (y == 0 && m_prev_y != 0) ? 1 : 0;
      if (tick != 0) begin
        m_mode = int'(mode);
        m_sc = int'(solid_color);
        if (!pause) begin
          m_cnt = (m_cnt + 1) & 16'hFFFF;
          bounce(m_bx, m_dx, H - BOX);
          bounce(m_by, m_dy, V - BOX);
          m_scroll = (m_scroll + SPEED) % H;
        end
      end
      m_prev_y = y;
    end
    cq.push_back('{cyc + 2, rst ? 0 : exp_color(x, y, a)});
    tq.push_back('{cyc + 1, m_cnt | (tick << 16)});
    @(posedge clock);
    #1;
  endtask

  task automatic tick_frame();
    drive($urandom_range(0, H - 1), $urandom_range(1, V - 1), 1, 1'b0);
    drive($urandom_range(0, H - 1), 0, 1, 1'b0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) drive($urandom_range(0, H - 1), $urandom_range(0, V - 1), 1, 1'b1);
  endtask

  // Monitor: pop and compare every expectation that has come due.
  always @(negedge clock) begin
    while (cq.size() > 0 && cq[0].due <= cyc) begin
      ce = cq.pop_front();
      n_checks++;
      if (color_out === 8'(ce.val)) n_pass++;
      else $display("FAIL color cyc=%0d got=%h exp=%h", cyc, color_out, 8'(ce.val));
    end
    while (tq.size() > 0 && tq[0].due <= cyc) begin
      te = tq.pop_front();
      n_checks++;
      if (frame_tick === te.val[16] && frame_cnt === te.val[15:0]) n_pass++;
      else $display("FAIL frame cyc=%0d got tick=%b cnt=%0d exp tick=%b cnt=%0d",
                    cyc, frame_tick, frame_cnt, te.val[16], te.val[15:0]);
    end
  end

  initial begin
    // Reset with active high, then no tick on release with y staying 0.
    do_reset(3);
    drive(5, 0, 1, 1'b0);
    drive(6, 0, 1, 1'b0);

    // Bars and latency after one frame wrap.
    mode = 3'd1;
    tick_frame();
    drive(80, 10, 1, 1'b0);
    drive(560, 10, 1, 1'b0);
    drive(80, 10, 0, 1'b0);
    drive(0, 10, 1, 1'b0);
    drive(639, 10, 1, 1'b0);

    // Mid-frame mode/colour change waits for the next tick.
    drive(80, 100, 1, 1'b0);
    mode = 3'd0; solid_color = 8'hE0;
    drive(80, 100, 1, 1'b0);
    drive(560, 101, 1, 1'b0);
    tick_frame();
    drive(80, 10, 1, 1'b0);

    // Grid boundaries and out-of-range coordinates.
    mode = 3'd4;
    tick_frame();
    drive(639, 5, 1, 1'b0); drive(638, 5, 1, 1'b0); drive(64, 5, 1, 1'b0);
    drive(5, 479, 1, 1'b0); drive(640, 5, 1, 1'b0); drive(5, 480, 1, 1'b0);

    // Bouncing box across the right-edge bounce.
    do_reset(2);
    mode = 3'd5; solid_color = 8'h5A; pause = 1'b0;
    for (int t = 1; t <= 153; t++) begin
      tick_frame();
      if (t >= 151) begin
        drive(m_bx, m_by, 1, 1'b0);
        drive(m_bx + BOX, m_by, 1, 1'b0);
        drive(m_bx + BOX - 1, m_by + BOX - 1, 1, 1'b0);
        drive(m_bx, m_by + BOX, 1, 1'b0);
      end
    end

    // Pause: ticks still pulse and latch colour, animation and counter hold.
    pause = 1'b1;
    for (int t = 0; t < 5; t++) begin
      solid_color = 8'($urandom);
      tick_frame();
      drive(m_bx, m_by, 1, 1'b0);
    end
    pause = 1'b0;
    tick_frame();
    drive(m_bx, m_by, 1, 1'b0);

    // Scroll wrap.
    do_reset(1);
    mode = 3'd6;
    for (int t = 0; t < 160; t++) tick_frame();
    drive(0, 10, 1, 1'b0);
    for (int t = 0; t < 20; t++) tick_frame();
    drive(0, 10, 1, 1'b0);
    drive(559, 10, 1, 1'b0);

    // Randomized frames with mode/colour/pause changes and occasional resets.
    for (int f = 0; f < 200; f++) begin
      for (int p = 0; p < int'($urandom_range(1, 8)); p++) begin
        if ($urandom_range(0, 5) == 0) begin
          mode = 3'($urandom_range(0, 7));
          solid_color = 8'($urandom);
        end
        if ($urandom_range(0, 9) == 0) pause = ~pause;
        drive($urandom_range(0, 700), $urandom_range(1, 520),
              ($urandom_range(0, 7) != 0) ? 1 : 0, ($urandom_range(0, 49) == 0));
      end
      drive($urandom_range(0, 700), 0, 1, 1'b0);
    end

    // Drain the pipeline with a bounded wait.
    drive(0, 1, 0, 1'b0);
    drive(0, 1, 0, 1'b0);
    repeat (5) @(posedge clock);
    #1;
    n_checks++;
    if (cq.size() == 0 && tq.size() == 0) n_pass++;
    else $display("FAIL drain got=%0d/%0d pending exp=0", cq.size(), tq.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
